ctrl_pipeline: RTL and testbench
================================

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port EX_ctrl_i  input  5  decoded ALUOp[4:2], ALUSrc[1], RegDst[0] of the ID-stage instruction.
REQ-005 SHALL have port MEM_ctrl_i  input  2  MEM_cs[1], MEM_we[0] of the ID-stage instruction.
REQ-006 SHALL have port WB_ctrl_i  input  1  Reg_we of the ID-stage instruction.
REQ-007 SHALL have ports rs_i, rt_i, rd_i  input  REG_AW  register fields of the ID-stage instruction.
REQ-008 SHALL have port flush_i  input  1  squash the ID-stage instruction (taken BEQ or J).
REQ-009 SHALL have port EX_ctrl_o  output  5  EX-stage control from the ID/EX register.
REQ-010 SHALL have port MEM_ctrl_o  output  2  MEM-stage control from the EX/MEM register.
REQ-011 SHALL have port WB_ctrl_o  output  1  WB-stage Reg_we from the MEM/WB register.
REQ-012 SHALL have ports mem_dst_o, wb_dst_o  output  REG_AW  destination register in MEM and WB.
REQ-013 SHALL have port stall_o  output  1  load-use hazard; PC and IF/ID hold when high.
REQ-014 SHALL have ports fwd_a_o, fwd_b_o  output  2  ALU operand source: 00 register file, 10 EX/MEM, 01 MEM/WB.

Function
REQ-015 SHALL keep three registers:
- ID/EX: EX, MEM and WB control, plus rs, rt, rd.
- EX/MEM: MEM and WB control, plus dst.
- MEM/WB: WB control, plus dst.
REQ-016 SHALL compute the EX-stage dst as rd when RegDst=1, otherwise rt, and capture it into EX/MEM.
REQ-017 SHALL give latency from ID inputs to EX_ctrl_o, MEM_ctrl_o and WB_ctrl_o of 1, 2 and 3 cycles respectively.
REQ-018 SHALL drive stall_o combinationally high when all of the following hold:
- ID/EX holds a load: MEM_cs=1, MEM_we=0, Reg_we=1.
- ID/EX rt is not 0.
- ID/EX rt equals rs_i or rt_i.
- flush_i=0.
REQ-019 SHALL load a bubble (all control and address fields zero) into ID/EX when stall_o=1 or flush_i=1; otherwise ID/EX captures the ID inputs.
REQ-020 SHALL advance EX/MEM and MEM/WB every cycle regardless of stall_o or flush_i.
REQ-021 SHALL set fwd_a_o=10 when EX/MEM Reg_we=1, EX/MEM dst is not 0 and EX/MEM dst equals ID/EX rs; else 01 when the same conditions hold for MEM/WB; else 00.
REQ-022 SHALL derive fwd_b_o identically to fwd_a_o, using ID/EX rt.
REQ-023 SHALL give EX/MEM priority over MEM/WB when both match.
REQ-024 SHALL never forward from, nor stall on, register 0.
REQ-025 SHALL give flush_i priority when flush_i and a hazard coincide: bubble inserted, stall_o=0.
REQ-026 SHALL drive stall_o and the forwarding outputs purely combinationally from registered state and ID inputs, with no added latency.

Reset
REQ-027 SHALL, while rst_i=1 at a clock edge, clear all three registers to zero. This gives zero on EX_ctrl_o, MEM_ctrl_o, WB_ctrl_o, mem_dst_o and wb_dst_o, which in turn forces stall_o=0 and fwd_a_o=fwd_b_o=00.
REQ-028 SHALL, on reset asserted mid-operation, discard all in-flight control; no store or register write may issue in the cycle after reset.

Structure
REQ-029 SHALL take the following from the shared control package: control-field widths, bit positions (ALUOp, ALUSrc, RegDst, MEM_cs, MEM_we, Reg_we) and the fwd encodings 00/10/01.
REQ-030 SHALL instantiate sub-module fwd_select twice (operand A and operand B); it compares one source register against the EX/MEM and MEM/WB destinations.

Verification
REQ-031 SHALL verify load-use: LW writing rt=8 in EX while ID has rs=8 -> stall_o=1 for one cycle, EX_ctrl_o=0 next cycle, then fwd_a_o=01.
REQ-032 SHALL verify back-to-back ADD: first writes rd=3, second reads rs=3 and rt=3 -> fwd_a_o=fwd_b_o=10.
REQ-033 SHALL verify double-match priority: EX/MEM and MEM/WB both dst=5, ID/EX rs=5 -> fwd_a_o=10.
REQ-034 SHALL verify register 0: ADDI with dst=0 followed by a reader of rs=0 -> fwd_a_o=00 and stall_o=0.
REQ-035 SHALL verify flush with hazard: flush_i=1 together with load-use -> stall_o=0, bubble in ID/EX, SW control never reaches MEM_ctrl_o.
REQ-036 SHALL verify reset mid-stream: rst_i=1 for one cycle with SW in EX -> MEM_ctrl_o=00 next cycle, all outputs zero.

Source files
------------

// File: rtl/ctrl_pipeline_pkg.sv
// Shared control-field layout and forwarding encodings for the pipeline control path.
package ctrl_pipeline_pkg;

    // Control-field widths
    localparam int unsigned EX_W  = 5;
    localparam int unsigned MEM_W = 2;
    localparam int unsigned WB_W  = 1;
    localparam int unsigned FWD_W = 2;

    // EX control bit positions: ALUOp[4:2], ALUSrc[1], RegDst[0]
    localparam int unsigned ALUOP_LSB  = 2;
    localparam int unsigned ALUOP_W    = 3;
    localparam int unsigned ALUSRC_BIT = 1;
    localparam int unsigned REGDST_BIT = 0;

    // MEM control bit positions: MEM_cs[1], MEM_we[0]
    localparam int unsigned MEM_CS_BIT = 1;
    localparam int unsigned MEM_WE_BIT = 0;

    // WB control bit position: Reg_we[0]
    localparam int unsigned REG_WE_BIT = 0;

    // ALU operand source select
    localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;
    localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/ctrl_pipeline_fwd_select.sv
// Forwarding selector for one ALU operand: compares a source register against the
// EX/MEM and MEM/WB destinations, younger result first, never matching register 0.
module fwd_select
    import ctrl_pipeline_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic              exmem_we_i,
    input  logic [REG_AW-1:0] exmem_dst_i,
    input  logic              memwb_we_i,
    input  logic [REG_AW-1:0] memwb_dst_i,
    output logic [FWD_W-1:0]  fwd_o
);

    logic exmem_hit;
    logic memwb_hit;

    // Pick the youngest in-flight producer of src_i, else the register file
    always_comb begin
        exmem_hit = exmem_we_i && (exmem_dst_i != '0) && (exmem_dst_i == src_i);
        memwb_hit = memwb_we_i && (memwb_dst_i != '0) && (memwb_dst_i == src_i);
        fwd_o     = FWD_RF;
        if (exmem_hit) begin
            fwd_o = FWD_EXMEM;
        end else if (memwb_hit) begin
            fwd_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Pipeline control path: ID/EX, EX/MEM, MEM/WB control registers with load-use
// stall detection, flush bubbling and operand forwarding selection.
module ctrl_pipeline
    import ctrl_pipeline_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [EX_W-1:0]   EX_ctrl_i,
    input  logic [MEM_W-1:0]  MEM_ctrl_i,
    input  logic [WB_W-1:0]   WB_ctrl_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              flush_i,
    output logic [EX_W-1:0]   EX_ctrl_o,
    output logic [MEM_W-1:0]  MEM_ctrl_o,
    output logic [WB_W-1:0]   WB_ctrl_o,
    output logic [REG_AW-1:0] mem_dst_o,
    output logic [REG_AW-1:0] wb_dst_o,
    output logic              stall_o,
    output logic [FWD_W-1:0]  fwd_a_o,
    output logic [FWD_W-1:0]  fwd_b_o
);

    // ID/EX register
    logic [EX_W-1:0]   idex_ex_q,  idex_ex_d;
    logic [MEM_W-1:0]  idex_mem_q, idex_mem_d;
    logic [WB_W-1:0]   idex_wb_q,  idex_wb_d;
    logic [REG_AW-1:0] idex_rs_q,  idex_rs_d;
    logic [REG_AW-1:0] idex_rt_q,  idex_rt_d;
    logic [REG_AW-1:0] idex_rd_q,  idex_rd_d;

    // EX/MEM register
    logic [MEM_W-1:0]  exmem_mem_q, exmem_mem_d;
    logic [WB_W-1:0]   exmem_wb_q,  exmem_wb_d;
    logic [REG_AW-1:0] exmem_dst_q, exmem_dst_d;

    // MEM/WB register
    logic [WB_W-1:0]   memwb_wb_q,  memwb_wb_d;
    logic [REG_AW-1:0] memwb_dst_q, memwb_dst_d;

    logic idex_is_load;
    logic stall;
    logic bubble;

    // Load-use hazard detection; a flush squashes the consumer so no stall is needed
    always_comb begin
        idex_is_load = idex_mem_q[MEM_CS_BIT] && !idex_mem_q[MEM_WE_BIT]
                       && idex_wb_q[REG_WE_BIT];
        stall        = idex_is_load && (idex_rt_q != '0)
                       && ((idex_rt_q == rs_i) || (idex_rt_q == rt_i)) && !flush_i;
        bubble       = stall || flush_i;
    end

    // Next-state for all three pipeline registers
    always_comb begin
        idex_ex_d   = EX_ctrl_i;
        idex_mem_d  = MEM_ctrl_i;
        idex_wb_d   = WB_ctrl_i;
        idex_rs_d   = rs_i;
        idex_rt_d   = rt_i;
        idex_rd_d   = rd_i;
        if (bubble) begin
            idex_ex_d  = '0;
            idex_mem_d = '0;
            idex_wb_d  = '0;
            idex_rs_d  = '0;
            idex_rt_d  = '0;
            idex_rd_d  = '0;
        end
        // Later stages always advance, independent of stall and flush
        exmem_mem_d = idex_mem_q;
        exmem_wb_d  = idex_wb_q;
        exmem_dst_d = idex_ex_q[REGDST_BIT] ? idex_rd_q : idex_rt_q;
        memwb_wb_d  = exmem_wb_q;
        memwb_dst_d = exmem_dst_q;
    end

    // Pipeline register update with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idex_ex_q   <= '0;
            idex_mem_q  <= '0;
            idex_wb_q   <= '0;
            idex_rs_q   <= '0;
            idex_rt_q   <= '0;
            idex_rd_q   <= '0;
            exmem_mem_q <= '0;
            exmem_wb_q  <= '0;
            exmem_dst_q <= '0;
            memwb_wb_q  <= '0;
            memwb_dst_q <= '0;
        end else begin
            idex_ex_q   <= idex_ex_d;
            idex_mem_q  <= idex_mem_d;
            idex_wb_q   <= idex_wb_d;
            idex_rs_q   <= idex_rs_d;
            idex_rt_q   <= idex_rt_d;
            idex_rd_q   <= idex_rd_d;
            exmem_mem_q <= exmem_mem_d;
            exmem_wb_q  <= exmem_wb_d;
            exmem_dst_q <= exmem_dst_d;
            memwb_wb_q  <= memwb_wb_d;
            memwb_dst_q <= memwb_dst_d;
        end
    end

    fwd_select #(
        .REG_AW (REG_AW)
    ) u_fwd_a (
        .src_i       (idex_rs_q),
        .exmem_we_i  (exmem_wb_q[REG_WE_BIT]),
        .exmem_dst_i (exmem_dst_q),
        .memwb_we_i  (memwb_wb_q[REG_WE_BIT]),
        .memwb_dst_i (memwb_dst_q),
        .fwd_o       (fwd_a_o)
    );

    fwd_select #(
        .REG_AW (REG_AW)
    ) u_fwd_b (
        .src_i       (idex_rt_q),
        .exmem_we_i  (exmem_wb_q[REG_WE_BIT]),
        .exmem_dst_i (exmem_dst_q),
        .memwb_we_i  (memwb_wb_q[REG_WE_BIT]),
        .memwb_dst_i (memwb_dst_q),
        .fwd_o       (fwd_b_o)
    );

    // Stage outputs come straight from the registers
    always_comb begin
        EX_ctrl_o  = idex_ex_q;
        MEM_ctrl_o = exmem_mem_q;
        WB_ctrl_o  = memwb_wb_q;
        mem_dst_o  = exmem_dst_q;
        wb_dst_o   = memwb_dst_q;
        stall_o    = stall;
    end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline: an instruction-level model of the three
// stages, directed hazard scenarios, then randomized instruction streams.
module tb_ctrl_pipeline;
    import ctrl_pipeline_pkg::*;

    localparam int unsigned AW = 5;

    typedef struct packed {
        logic [4:0]    ex;
        logic [1:0]    mem;
        logic          wb;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
    } instr_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [4:0]    EX_ctrl_i;
    logic [1:0]    MEM_ctrl_i;
    logic          WB_ctrl_i;
    logic [AW-1:0] rs_i, rt_i, rd_i;
    logic          flush_i;
    logic [4:0]    EX_ctrl_o;
    logic [1:0]    MEM_ctrl_o;
    logic          WB_ctrl_o;
    logic [AW-1:0] mem_dst_o, wb_dst_o;
    logic          stall_o;
    logic [1:0]    fwd_a_o, fwd_b_o;

    int checks = 0;
    int errors = 0;

    // Model: the instruction occupying each stage, plus the current ID-stage inputs
    instr_t s_ex, s_mem, s_wb, cur;
    logic   cur_flush, cur_rst;
    logic   exp_stall;

    always #5 clk = ~clk;

    ctrl_pipeline #(
        .REG_AW (AW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .EX_ctrl_i  (EX_ctrl_i),
        .MEM_ctrl_i (MEM_ctrl_i),
        .WB_ctrl_i  (WB_ctrl_i),
        .rs_i       (rs_i),
        .rt_i       (rt_i),
        .rd_i       (rd_i),
        .flush_i    (flush_i),
        .EX_ctrl_o  (EX_ctrl_o),
        .MEM_ctrl_o (MEM_ctrl_o),
        .WB_ctrl_o  (WB_ctrl_o),
        .mem_dst_o  (mem_dst_o),
        .wb_dst_o   (wb_dst_o),
        .stall_o    (stall_o),
        .fwd_a_o    (fwd_a_o),
        .fwd_b_o    (fwd_b_o)
    );

    function automatic instr_t mk(input string op, input int rs, input int rt, input int rd);
        instr_t i;
        i    = '0;
        i.rs = AW'(rs);
        i.rt = AW'(rt);
        i.rd = AW'(rd);
        case (op)
            "ADD":  begin i.ex = 5'b01001; i.mem = 2'b00; i.wb = 1'b1; end
            "ADDI": begin i.ex = 5'b00010; i.mem = 2'b00; i.wb = 1'b1; end
            "LW":   begin i.ex = 5'b00010; i.mem = 2'b10; i.wb = 1'b1; end
            "SW":   begin i.ex = 5'b00010; i.mem = 2'b11; i.wb = 1'b0; end
            default: i = '0;
        endcase
        return i;
    endfunction

    // Destination written by an instruction: rd for R-type (RegDst), else rt
    function automatic logic [AW-1:0] dst_of(input instr_t i);
        return i.ex[0] ? i.rd : i.rt;
    endfunction

    function automatic logic [1:0] model_fwd(input logic [AW-1:0] src);
        if (s_mem.wb && dst_of(s_mem) != 0 && dst_of(s_mem) == src) return 2'b10;
        if (s_wb.wb && dst_of(s_wb) != 0 && dst_of(s_wb) == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic model_stall();
        logic load;
        load = (s_ex.mem == 2'b10) && s_ex.wb;
        return load && s_ex.rt != 0 && (s_ex.rt == cur.rs || s_ex.rt == cur.rt) && !cur_flush;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive ID inputs mid-cycle and compare every output against the model
    task automatic apply(input instr_t id, input logic flush, input logic rst);
        @(negedge clk);
        cur        = id;
        cur_flush  = flush;
        cur_rst    = rst;
        EX_ctrl_i  = id.ex;
        MEM_ctrl_i = id.mem;
        WB_ctrl_i  = id.wb;
        rs_i       = id.rs;
        rt_i       = id.rt;
        rd_i       = id.rd;
        flush_i    = flush;
        rst_i      = rst;
        #1;
        exp_stall = model_stall();
        chk("ex_ctrl",  32'(EX_ctrl_o),  32'(s_ex.ex));
        chk("mem_ctrl", 32'(MEM_ctrl_o), 32'(s_mem.mem));
        chk("wb_ctrl",  32'(WB_ctrl_o),  32'(s_wb.wb));
        chk("mem_dst",  32'(mem_dst_o),  32'(dst_of(s_mem)));
        chk("wb_dst",   32'(wb_dst_o),   32'(dst_of(s_wb)));
        chk("stall",    32'(stall_o),    32'(exp_stall));
        chk("fwd_a",    32'(fwd_a_o),    32'(model_fwd(s_ex.rs)));
        chk("fwd_b",    32'(fwd_b_o),    32'(model_fwd(s_ex.rt)));
    endtask

    // Advance the model across a rising edge
    task automatic tick();
        logic bub;
        bub = model_stall() || cur_flush;
        @(posedge clk);
        if (cur_rst) begin
            s_ex = '0; s_mem = '0; s_wb = '0;
        end else begin
            s_wb  = s_mem;
            s_mem = s_ex;
            s_ex  = bub ? '0 : cur;
        end
    endtask

    task automatic run(input instr_t id, input logic flush, input logic rst);
        apply(id, flush, rst);
        tick();
    endtask

    instr_t nop;
    instr_t id;
    logic   hold;

    initial begin
        nop   = '0;
        s_ex  = '0; s_mem = '0; s_wb = '0;
        cur   = '0; cur_flush = 1'b0; cur_rst = 1'b1;
        {EX_ctrl_i, MEM_ctrl_i, WB_ctrl_i, rs_i, rt_i, rd_i, flush_i} = '0;
        rst_i = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state
        apply(nop, 1'b0, 1'b0);
        chk("rst_ex", 32'(EX_ctrl_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        tick();

        // Load-use: LW rt=8 then reader rs=8
        run(mk("LW", 1, 8, 0), 1'b0, 1'b0);
        apply(mk("ADD", 8, 2, 9), 1'b0, 1'b0);
        chk("lu_stall", 32'(stall_o), 32'd1);
        tick();
        apply(mk("ADD", 8, 2, 9), 1'b0, 1'b0);
        chk("lu_bubble", 32'(EX_ctrl_o), 32'd0);
        chk("lu_nostall", 32'(stall_o), 32'd0);
        tick();
        apply(nop, 1'b0, 1'b0);
        chk("lu_fwd_a", 32'(fwd_a_o), 32'b01);
        tick();
        repeat (3) run(nop, 1'b0, 1'b0);

        // Back-to-back ADD
        run(mk("ADD", 1, 2, 3), 1'b0, 1'b0);
        run(mk("ADD", 3, 3, 4), 1'b0, 1'b0);
        apply(nop, 1'b0, 1'b0);
        chk("b2b_fwd_a", 32'(fwd_a_o), 32'b10);
        chk("b2b_fwd_b", 32'(fwd_b_o), 32'b10);
        tick();
        repeat (3) run(nop, 1'b0, 1'b0);

        // Double match: EX/MEM wins
        run(mk("ADDI", 1, 5, 0), 1'b0, 1'b0);
        run(mk("ADDI", 0, 5, 0), 1'b0, 1'b0);
        run(mk("ADD", 5, 0, 6), 1'b0, 1'b0);
        apply(nop, 1'b0, 1'b0);
        chk("dbl_fwd_a", 32'(fwd_a_o), 32'b10);
        tick();
        repeat (3) run(nop, 1'b0, 1'b0);

        // Register 0 never forwards nor stalls
        run(mk("ADDI", 1, 0, 0), 1'b0, 1'b0);
        run(mk("ADD", 0, 0, 7), 1'b0, 1'b0);
        apply(nop, 1'b0, 1'b0);
        chk("r0_fwd_a", 32'(fwd_a_o), 32'b00);
        tick();
        run(mk("LW", 1, 0, 0), 1'b0, 1'b0);
        apply(mk("ADD", 0, 0, 7), 1'b0, 1'b0);
        chk("r0_stall", 32'(stall_o), 32'd0);
        tick();
        repeat (3) run(nop, 1'b0, 1'b0);

        // Flush coinciding with load-use: SW squashed, no stall
        run(mk("LW", 1, 8, 0), 1'b0, 1'b0);
        apply(mk("SW", 8, 8, 0), 1'b1, 1'b0);
        chk("fl_stall", 32'(stall_o), 32'd0);
        tick();
        apply(nop, 1'b0, 1'b0);
        chk("fl_bubble", 32'(EX_ctrl_o), 32'd0);
        tick();
        apply(nop, 1'b0, 1'b0);
        chk("fl_mem_ctrl", 32'(MEM_ctrl_o), 32'd0);
        tick();
        repeat (2) run(nop, 1'b0, 1'b0);

        // Reset mid-stream with SW in EX
        run(mk("ADD", 1, 2, 3), 1'b0, 1'b0);
        run(mk("SW", 3, 4, 0), 1'b0, 1'b0);
        run(nop, 1'b0, 1'b1);
        apply(nop, 1'b0, 1'b0);
        chk("mrst_mem_ctrl", 32'(MEM_ctrl_o), 32'd0);
        chk("mrst_all", 32'({EX_ctrl_o, MEM_ctrl_o, WB_ctrl_o, mem_dst_o, wb_dst_o,
                             stall_o, fwd_a_o, fwd_b_o}), 32'd0);
        tick();

        // Randomized stream; ID is held while the model expects a stall
        hold = 1'b0;
        id   = nop;
        for (int n = 0; n < 600; n++) begin
            if (!hold) begin
                case ($urandom_range(0, 4))
                    0: id = mk("ADD",  $urandom_range(0, 7), $urandom_range(0, 7),
                               $urandom_range(0, 7));
                    1: id = mk("ADDI", $urandom_range(0, 7), $urandom_range(0, 7), 0);
                    2: id = mk("LW",   $urandom_range(0, 7), $urandom_range(0, 7), 0);
                    3: id = mk("SW",   $urandom_range(0, 7), $urandom_range(0, 7), 0);
                    default: id = nop;
                endcase
            end
            apply(id, ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
            hold = exp_stall;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
